// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: word geometry,
// the word type and the address range check used on both ports.
package dm_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int DEFAULT_DEPTH = 256;

    typedef logic [31:0] word_t;

    // A word index is in range only when no bit above the index field is set,
    // so out-of-range addresses never alias onto a low word.
    function automatic logic addr_in_range(input word_t addr, input int addr_bits);
        return (addr >> addr_bits) == 32'd0;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle RISC-V datapath.
// Port contract: MemWrite is sampled on the rising clk edge and stores
// write_data into word addr; read_data is combinational and shows
// mem[addr] while MemRead is high and addr is in range, otherwise zero.
// A store becomes visible on read_data just after its edge (no bypass),
// and rst clears every word immediately, overriding any store.
module data_memory #(
    parameter int DATA_WIDTH = dm_pkg::DATA_WIDTH,
    parameter int DEPTH      = dm_pkg::DEFAULT_DEPTH,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  rst
);
    import dm_pkg::*;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  in_range;
    logic [ADDR_BITS-1:0]  idx;

    assign in_range = addr_in_range(addr, ADDR_BITS);
    assign idx      = addr[ADDR_BITS-1:0];

    // Storage: asynchronous clear wins over a store; stores land on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite && in_range) begin
            mem_q[idx] <= write_data;
        end
    end

    // Load path: zero unless a read is enabled and the address is in range.
    always_comb begin
        read_data = '0;
        if (MemRead && in_range) begin
            read_data = mem_q[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, hand-written reset
// sequences, then randomized traffic against an array reference model.
module tb_data_memory;

    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [DEPTH];

    typedef struct {
        string         name;
        logic          mr;
        logic          mw;
        logic [31:0]   a;
        logic [DW-1:0] wd;
        bit            clk_edge;
        logic [DW-1:0] exp_pre;
        logic [DW-1:0] exp_post;
    } vec_t;

    vec_t vecs [13];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    data_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rst        (rst)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic mr, input logic mw, input logic [31:0] a,
                         input logic [DW-1:0] wd);
        MemRead    = mr;
        MemWrite   = mw;
        addr       = a;
        write_data = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, '0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [DW-1:0] exp);
        n_checks++;
        if (read_data === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: read_data=%h expected=%h (addr=%h MemRead=%b)",
                     name, read_data, exp, addr, MemRead);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic mr, input logic [31:0] a);
        if (mr && a < DEPTH) return model[a];
        return '0;
    endfunction

    task automatic check_model(input string name);
        exp_q.push_back(model_read(MemRead, addr));
        check(name, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, '0);

        // Reset state.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, '0);   #1 check("reset_addr0", '0);
        addr = 32'd5;                   #1 check("reset_addr5", '0);
        addr = 32'd255;                 #1 check("reset_addr255", '0);

        // Directed table: pre = before the edge, post = just after it.
        vecs[0]  = '{"wr5",          1'b0, 1'b1, 32'd5,     32'hDEADCAFE, 1'b1, 32'h0,        32'h0};
        vecs[1]  = '{"wr10",         1'b0, 1'b1, 32'd10,    32'h12345678, 1'b1, 32'h0,        32'h0};
        vecs[2]  = '{"rd5",          1'b1, 1'b0, 32'd5,     32'h0,        1'b1, 32'hDEADCAFE, 32'hDEADCAFE};
        vecs[3]  = '{"rd10",         1'b1, 1'b0, 32'd10,    32'h0,        1'b1, 32'h12345678, 32'h12345678};
        vecs[4]  = '{"gate_off5",    1'b0, 1'b0, 32'd5,     32'h0,        1'b0, 32'h0,        32'h0};
        vecs[5]  = '{"gate_on5",     1'b1, 1'b0, 32'd5,     32'h0,        1'b0, 32'hDEADCAFE, 32'h0};
        vecs[6]  = '{"rw_same5",     1'b1, 1'b1, 32'd5,     32'hA5A5A5A5, 1'b1, 32'hDEADCAFE, 32'hA5A5A5A5};
        vecs[7]  = '{"oor_wr256",    1'b1, 1'b1, 32'd256,   32'hFFFFFFFF, 1'b1, 32'h0,        32'h0};
        vecs[8]  = '{"oor_rd256",    1'b1, 1'b0, 32'd256,   32'h0,        1'b0, 32'h0,        32'h0};
        vecs[9]  = '{"word0_clean",  1'b1, 1'b0, 32'd0,     32'h0,        1'b0, 32'h0,        32'h0};
        vecs[10] = '{"oor_wr105",    1'b0, 1'b1, 32'h105,   32'h11111111, 1'b1, 32'h0,        32'h0};
        vecs[11] = '{"no_alias5",    1'b1, 1'b0, 32'd5,     32'h0,        1'b0, 32'hA5A5A5A5, 32'h0};
        vecs[12] = '{"oor_rd_hi",    1'b1, 1'b0, 32'h80000005, 32'h0,     1'b0, 32'h0,        32'h0};

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            drive(vecs[v].mr, vecs[v].mw, vecs[v].a, vecs[v].wd);
            #1 check({vecs[v].name, "_pre"}, vecs[v].exp_pre);
            if (vecs[v].clk_edge) begin
                @(posedge clk);
                #1 check({vecs[v].name, "_post"}, vecs[v].exp_post);
            end
        end

        // Reset mid-operation: word 5 holds A5A5A5A5, word 10 holds 12345678.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd5, '0);
        #1 check("pre_rst_rd5", 32'hA5A5A5A5);
        #2 rst = 1'b1;
        #1 check("rst_async_clear", '0);
        drive(1'b1, 1'b1, 32'd10, 32'h77777777);
        @(posedge clk);
        #1 check("rst_blocks_write", '0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'd10, '0);
        #1 check("after_rst_rd10", '0);
        addr = 32'd5;
        #1 check("after_rst_rd5", '0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'd10, 32'h0BADF00D);
        @(posedge clk);
        #1 check("first_write_after_rst", 32'h0BADF00D);

        // Randomized traffic against the array model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            MemRead    = 1'($urandom_range(0, 1));
            MemWrite   = 1'($urandom_range(0, 1));
            write_data = $urandom;
            case ($urandom_range(0, 3))
                0:       addr = $urandom;
                1:       addr = DEPTH + $urandom_range(0, 3);
                2:       addr = $urandom_range(0, DEPTH - 1);
                default: addr = $urandom_range(0, 15);
            endcase
            #1 check_model("rand_pre");
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                for (int k = 0; k < DEPTH; k++) model[k] = '0;
                #1 check_model("rand_rst");
                #1 rst = 1'b0;
            end
            @(posedge clk);
            if (MemWrite && addr < DEPTH) model[addr] = write_data;
            #1 check_model("rand_post");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
